// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters sharing one 3-to-8 decoded resource.
// Registered one-hot grant, decoder select/enable, hold-time limit with timeout pulse.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       e,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [2:0] idx_reg, idx_next;
  logic [7:0] hcnt_reg, hcnt_next;
  logic [7:0] gnt_reg, gnt_next;
  logic [2:0] sel_reg, sel_next;
  logic       e_reg, e_next;
  logic       timeout_reg, timeout_next;

  logic [7:0] rot_req;
  logic [2:0] offset;
  logic [2:0] winner;

  // Rotate requests so bit 0 is the line at ptr; lowest set bit then wins.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = req[3'(ptr_reg + 3'(gi))];
    end
  endgenerate

  always_comb begin
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) offset = 3'(k);
    end
  end

  assign winner = ptr_reg + offset;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    idx_next     = idx_reg;
    hcnt_next    = hcnt_reg;
    gnt_next     = gnt_reg;
    sel_next     = sel_reg;
    e_next       = e_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          idx_next   = winner;
          gnt_next   = 8'b1 << winner;
          sel_next   = winner;
          e_next     = 1'b1;
          hcnt_next  = 8'd0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        hcnt_next = hcnt_reg + 8'd1;
        if (!req[idx_reg] || hcnt_reg == HOLD_LAST) begin
          state_next   = IDLE;
          gnt_next     = 8'h00;
          sel_next     = 3'd0;
          e_next       = 1'b0;
          ptr_next     = idx_reg + 3'd1;
          // A requester that lets go on its last allowed cycle is not a timeout.
          timeout_next = req[idx_reg];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= 3'd0;
      idx_reg     <= 3'd0;
      hcnt_reg    <= 8'd0;
      gnt_reg     <= 8'h00;
      sel_reg     <= 3'd0;
      e_reg       <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      idx_reg     <= idx_next;
      hcnt_reg    <= hcnt_next;
      gnt_reg     <= gnt_next;
      sel_reg     <= sel_next;
      e_reg       <= e_next;
      timeout_reg <= timeout_next;
    end
  end

  assign gnt       = gnt_reg;
  assign e         = e_reg;
  assign {a, b, c} = sel_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: directed test-plan steps plus random traffic,
// every cycle compared against a tenure-level reference model.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic       e, a, b, c, timeout;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .e(e), .a(a), .b(b), .c(c), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the resource, how long, where the rotation resumes.
  int   m_owner = -1;
  int   m_start = 0;
  int   m_held  = 0;
  bit   m_to    = 1'b0;
  int   order[$];
  logic [7:0] prev_gnt = 8'h00;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [7:0] rq);
    bit found;
    if (r) begin
      m_owner = -1; m_start = 0; m_held = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && rq[(m_start + k) % 8]) begin
          found   = 1'b1;
          m_owner = (m_start + k) % 8;
          m_held  = 1;
          order.push_back(m_owner);
        end
      end
    end else if (!rq[m_owner]) begin
      m_start = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b0;
    end else if (m_held == MH) begin
      m_start = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b1;
    end else begin
      m_held++; m_to = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_gnt;
    logic [2:0] exp_sel;
    logic [2:0] gnt_index;
    exp_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    exp_sel = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    chk("gnt", gnt, exp_gnt);
    chk("e", {7'd0, e}, {7'd0, m_owner >= 0});
    chk("sel", {5'd0, a, b, c}, {5'd0, exp_sel});
    chk("timeout", {7'd0, timeout}, {7'd0, m_to});
    chk("onehot", {7'd0, $countones(gnt) <= 1}, 8'd1);
    chk("e_vs_gnt", {7'd0, e}, {7'd0, |gnt});
    gnt_index = 3'd0;
    for (int k = 0; k < 8; k++) if (gnt[k]) gnt_index = 3'(k);
    chk("sel_vs_gnt", {5'd0, a, b, c}, {5'd0, gnt_index});
    if (prev_gnt != 8'h00 && gnt != 8'h00) chk("no_switch", gnt, prev_gnt);
    prev_gnt = gnt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(rst, req);
    #1;
    check_outputs();
  endtask

  initial begin
    int to_count;

    // Reset then single request on line 4
    rst = 1'b1; req = 8'h00;
    step(); step();
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_timeout", {7'd0, timeout}, 8'd0);
    rst = 1'b0;
    step();
    req = 8'h10;
    step();
    chk("t1_gnt", gnt, 8'h10);
    chk("t1_sel", {5'd0, a, b, c}, 8'h04);
    step(); step();
    chk("t1_gnt3", gnt, 8'h10);
    req = 8'h00;
    step();
    chk("t1_release", gnt, 8'h00);
    step();
    req = 8'h21;
    step();
    chk("t1_ptr5", gnt, 8'h20);
    req = 8'h00;
    step(); step();

    // Rotation fairness: each grantee drops after 2 cycles, re-raises a cycle later
    rst = 1'b1; step(); rst = 1'b0;
    order.delete();
    req = 8'hFF;
    for (int i = 0; i < 60 && order.size() < 9; i++) begin
      step();
      req = (m_owner >= 0 && m_held == 2) ? (8'hFF & ~8'(1 << m_owner)) : 8'hFF;
    end
    chk("t2_count", 8'(order.size()), 8'd9);
    for (int i = 0; i < 9 && i < order.size(); i++) chk("t2_order", 8'(order[i]), 8'(i % 8));
    req = 8'h00; step(); step();

    // Pointer wrap: line 7 is forced off with line 0 and 7 requesting
    rst = 1'b1; step(); rst = 1'b0;
    req = 8'h80;
    step();
    chk("t3_gnt7", gnt, 8'h80);
    req = 8'h81;
    for (int i = 0; i < 10 && gnt !== 8'h01; i++) step();
    chk("t3_wrap", gnt, 8'h01);
    req = 8'h00; step(); step();

    // Timeout alternation between lines 1 and 2
    rst = 1'b1; step(); rst = 1'b0;
    order.delete();
    req = 8'h06;
    to_count = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (timeout) to_count++;
    end
    chk("t4_timeouts", 8'(to_count), 8'd2);
    chk("t4_count", 8'(order.size()), 8'd3);
    if (order.size() == 3) begin
      chk("t4_first", 8'(order[0]), 8'd1);
      chk("t4_second", 8'(order[1]), 8'd2);
      chk("t4_third", 8'(order[2]), 8'd1);
    end
    req = 8'h00; step(); step();

    // Reset in the middle of a tenure
    rst = 1'b1; step(); rst = 1'b0;
    req = 8'h08;
    step();
    chk("t5_gnt3", gnt, 8'h08);
    req = 8'h0C;
    step();
    rst = 1'b1;
    step();
    chk("t5_rst_gnt", gnt, 8'h00);
    chk("t5_rst_e", {7'd0, e}, 8'd0);
    rst = 1'b0;
    step();
    chk("t5_regrant", gnt, 8'h04);

    // Random traffic with slowly changing request vectors
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
